// File: rtl/f32_vrdslot_sched_if.sv
// f32_vrdslot_sched_if: request/return/drain bus between read ports, banks and the slot scheduler
// Signals: rd_req/rd_bnk/rd_gnt per port, ret_cnt/sel/prt/ptr per bank,
//          drn_vld per port, common drn_slot, sticky err.
// master: requester/bank side, slave: scheduler side.
interface f32_vrdslot_sched_if #(
    parameter int NUMRDPT = 4,
    parameter int NUMVBNK = 4,
    parameter int BITRDPT = 2,
    parameter int BITRDLY = 5,
    parameter int BITVBNK = 2
);
    logic [NUMRDPT-1:0]                rd_req;
    logic [NUMRDPT-1:0][BITVBNK-1:0]   rd_bnk;
    logic [NUMRDPT-1:0]                rd_gnt;
    logic [NUMVBNK-1:0][1:0]           ret_cnt;
    logic [NUMVBNK-1:0][2:0]           sel;
    logic [NUMVBNK-1:0][2*BITRDPT-1:0] prt;
    logic [NUMVBNK-1:0][2*BITRDLY-1:0] ptr;
    logic [NUMRDPT-1:0]                drn_vld;
    logic [BITRDLY-1:0]                drn_slot;
    logic [1:0]                        err;
    modport master (output rd_req, rd_bnk, ret_cnt, input rd_gnt, sel, prt, ptr, drn_vld, drn_slot, err);
    modport slave (input rd_req, rd_bnk, ret_cnt, output rd_gnt, sel, prt, ptr, drn_vld, drn_slot, err);
endinterface

// File: rtl/f32_vrdslot_sched.sv
// f32_vrdslot_sched: read-slot scheduler and return sequencer for the virtual-bank read-data delay array
// Ports: clk, rst_n (async active-low), bus (slave): per-port rd_req/rd_bnk in, rd_gnt out;
//        per-bank ret_cnt in, sel/prt/ptr out; drn_vld per port, drn_slot, sticky err[1:0] out.
module f32_vrdslot_sched #(
    parameter int NUMRDPT    = 4,
    parameter int NUMVBNK    = 4,
    parameter int READ_DELAY = 30,
    parameter int BITRDPT    = 2,
    parameter int BITRDLY    = 5,
    parameter int BITVBNK    = 2,
    parameter int TAGDEPTH   = 8
) (
    input logic               clk,
    input logic               rst_n,
    f32_vrdslot_sched_if.slave bus
);
    localparam int BITTAG = $clog2(TAGDEPTH);
    localparam int TAGW   = BITRDPT + BITRDLY;
    typedef logic [NUMRDPT-1:0][READ_DELAY-1:0] slot_map_t;

    logic [BITRDLY-1:0]              cur_slot_q, cur_slot_d, drn_slot;
    slot_map_t                       pend_q, pend_d, fill_q, fill_d;
    logic [TAGW-1:0]                 mem_q [NUMVBNK][TAGDEPTH];
    logic [NUMVBNK-1:0][BITTAG-1:0]  rp_q, rp_d, wp_q, wp_d;
    logic [NUMVBNK-1:0][BITTAG:0]    cnt_q, cnt_d;
    logic [NUMVBNK-1:0][BITRDPT-1:0] rr_q, rr_d, win;
    logic [NUMVBNK-1:0]              push;
    logic [1:0]                      err_q, err_d, rc, npop;
    logic [TAGW-1:0]                 t0, t1, tg;
    logic [BITRDPT-1:0]              idx;
    logic                            fnd;

    always_comb begin
        drn_slot = (cur_slot_q == BITRDLY'(READ_DELAY-1)) ? '0 : cur_slot_q + 1'b1;
        cur_slot_d = drn_slot;
        pend_d = pend_q;
        fill_d = fill_q;
        rp_d = rp_q;
        wp_d = wp_q;
        cnt_d = cnt_q;
        rr_d = rr_q;
        err_d = err_q;
        push = '0;
        win = '0;
        rc = '0;
        npop = '0;
        t0 = '0;
        t1 = '0;
        tg = '0;
        idx = '0;
        fnd = 1'b0;
        bus.rd_gnt = '0;
        bus.sel = '0;
        bus.prt = '0;
        bus.ptr = '0;
        // Returns: pop in order, only as many tags as the bank actually holds.
        for (int b = 0; b < NUMVBNK; b++) begin
            rc = (bus.ret_cnt[b] == 2'd3) ? 2'd2 : bus.ret_cnt[b];
            npop = (cnt_q[b] >= (BITTAG+1)'(rc)) ? rc : cnt_q[b][1:0];
            if (rc != npop) err_d[1] = 1'b1;
            t0 = mem_q[b][rp_q[b]];
            t1 = mem_q[b][rp_q[b] + BITTAG'(1)];
            bus.sel[b] = (npop == 2'd2) ? 3'b100 : (npop == 2'd1) ? 3'b001 : 3'b000;
            for (int k = 0; k < 2; k++) begin
                if (npop > 2'(k)) begin
                    tg = (k == 1) ? t1 : t0;
                    bus.prt[b][k*BITRDPT +: BITRDPT] = tg[BITRDLY +: BITRDPT];
                    bus.ptr[b][k*BITRDLY +: BITRDLY] = tg[BITRDLY-1:0];
                    fill_d[tg[BITRDLY +: BITRDPT]][tg[BITRDLY-1:0]] = 1'b1;
                    // A fill landing on the slot being drained arrived too late.
                    if (tg[BITRDLY-1:0] == drn_slot) err_d[0] = 1'b1;
                end
            end
            rp_d[b] = rp_q[b] + BITTAG'(npop);
            cnt_d[b] = cnt_q[b] - (BITTAG+1)'(npop);
        end
        // Grants run after fills so a new assignment always starts with fill clear.
        for (int b = 0; b < NUMVBNK; b++) begin
            fnd = 1'b0;
            for (int i = 0; i < NUMRDPT; i++) begin
                idx = rr_q[b] + BITRDPT'(i);
                if (!fnd && bus.rd_req[idx] && bus.rd_bnk[idx] == BITVBNK'(b)) begin
                    fnd = 1'b1;
                    win[b] = idx;
                end
            end
            push[b] = rst_n && fnd && (cnt_q[b] != (BITTAG+1)'(TAGDEPTH));
            if (push[b]) begin
                bus.rd_gnt[win[b]] = 1'b1;
                rr_d[b] = win[b] + 1'b1;
                wp_d[b] = wp_q[b] + BITTAG'(1);
                cnt_d[b] = cnt_d[b] + (BITTAG+1)'(1);
                pend_d[win[b]][cur_slot_q] = 1'b1;
                fill_d[win[b]][cur_slot_q] = 1'b0;
            end
        end
        // Drain runs last so it wins over any same-cycle fill of drn_slot.
        for (int p = 0; p < NUMRDPT; p++) begin
            bus.drn_vld[p] = pend_q[p][drn_slot] & fill_q[p][drn_slot];
            if (pend_q[p][drn_slot] && !fill_q[p][drn_slot]) err_d[0] = 1'b1;
            pend_d[p][drn_slot] = 1'b0;
            fill_d[p][drn_slot] = 1'b0;
        end
        bus.drn_slot = drn_slot;
        bus.err = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_slot_q <= '0;
            pend_q <= '0;
            fill_q <= '0;
            rp_q <= '0;
            wp_q <= '0;
            cnt_q <= '0;
            rr_q <= '0;
            err_q <= '0;
        end else begin
            cur_slot_q <= cur_slot_d;
            pend_q <= pend_d;
            fill_q <= fill_d;
            rp_q <= rp_d;
            wp_q <= wp_d;
            cnt_q <= cnt_d;
            rr_q <= rr_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUMVBNK; b++) begin
            if (push[b]) mem_q[b][wp_q[b]] <= {win[b], cur_slot_q};
        end
    end
endmodule

// File: tb/tb_f32_vrdslot_sched.sv
// tb_f32_vrdslot_sched: directed scoreboard bench for the read-slot scheduler
module tb_f32_vrdslot_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    f32_vrdslot_sched_if bus ();
    f32_vrdslot_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {int id; int due;} ent_t;
    ent_t sb[$];
    int   bq[4][$];
    int   id_p[256], id_s[256], id_due[256];
    bit   exp_vld[256];
    int   nid = 0, cyc = 0, n_cmp = 0, n_fail = 0, mon_nv;
    ent_t mon_e;
    bit   run = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_gnt"}, 32'(bus.rd_gnt), 0);
        chk({pfx, "_sel"}, 32'(bus.sel), 0);
        chk({pfx, "_prt"}, 32'(bus.prt), 0);
        chk({pfx, "_ptr"}, 32'(bus.ptr), 0);
        chk({pfx, "_drn_vld"}, 32'(bus.drn_vld), 0);
        chk({pfx, "_drn_slot"}, 32'(bus.drn_slot), 1);
        chk({pfx, "_err"}, 32'(bus.err), 0);
    endtask

    // Drive one cycle of stimulus, check grants and return steering against the model.
    task automatic drive(input logic [3:0] req, input logic [7:0] bnk, input logic [7:0] ret, input logic [3:0] egnt);
        bus.rd_req = req;
        bus.rd_bnk = bnk;
        bus.ret_cnt = ret;
        #1;
        chk($sformatf("rd_gnt c%0d", cyc), 32'(bus.rd_gnt), 32'(egnt));
        for (int b = 0; b < 4; b++) begin
            int rc, n, id;
            logic [2:0] es;
            logic [3:0] ep;
            logic [9:0] et;
            rc = (ret[2*b +: 2] == 2'd3) ? 2 : int'(ret[2*b +: 2]);
            n = (rc < bq[b].size()) ? rc : bq[b].size();
            es = (n == 2) ? 3'b100 : (n == 1) ? 3'b001 : 3'b000;
            ep = '0;
            et = '0;
            for (int k = 0; k < n; k++) begin
                id = bq[b].pop_front();
                ep[2*k +: 2] = 2'(id_p[id]);
                et[5*k +: 5] = 5'(id_s[id]);
                exp_vld[id] = cyc < id_due[id];
            end
            chk($sformatf("sel[%0d] c%0d", b, cyc), 32'(bus.sel[b]), 32'(es));
            chk($sformatf("prt[%0d] c%0d", b, cyc), 32'(bus.prt[b]), 32'(ep));
            chk($sformatf("ptr[%0d] c%0d", b, cyc), 32'(bus.ptr[b]), 32'(et));
        end
        for (int p = 0; p < 4; p++) begin
            if (egnt[p]) begin
                id_p[nid] = p;
                id_s[nid] = cyc % 30;
                id_due[nid] = cyc + 29;
                exp_vld[nid] = 1'b0;
                sb.push_back('{nid, cyc + 29});
                bq[bnk[2*p +: 2]].push_back(nid);
                nid++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_to(input int t);
        while (cyc < t) begin
            drive(4'b0, 8'h0, 8'h0, 4'b0);
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            mon_nv = 0;
            chk($sformatf("drn_slot c%0d", cyc), 32'(bus.drn_slot), 32'((cyc + 1) % 30));
            while (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk($sformatf("drn_vld p%0d s%0d c%0d", id_p[mon_e.id], id_s[mon_e.id], cyc),
                    32'(bus.drn_vld[id_p[mon_e.id]]), 32'(exp_vld[mon_e.id]));
                mon_nv += int'(exp_vld[mon_e.id]);
            end
            chk($sformatf("drn_vld_count c%0d", cyc), 32'($countones(bus.drn_vld)), 32'(mon_nv));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rd_req = 4'b1111;
        bus.rd_bnk = 8'hE4;
        bus.ret_cnt = 8'hFF;
        #12;
        chk_reset("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b1;
        cyc = 0;
        // single read: port 0 -> bank 2 at slot 0
        drive(4'b0001, 8'h02, 8'h00, 4'b0001); tick();
        idle_to(5);
        drive(4'b0, 8'h0, 8'h10, 4'b0);
        chk("single_sel", 32'(bus.sel[2]), 32'h1);
        chk("single_prt", 32'(bus.prt[2][1:0]), 0);
        chk("single_ptr", 32'(bus.ptr[2][4:0]), 0);
        tick();
        // contention: ports 0,1,3 -> bank 1
        drive(4'b1011, 8'h45, 8'h00, 4'b0001); tick();
        drive(4'b1011, 8'h45, 8'h00, 4'b0010); tick();
        drive(4'b1011, 8'h45, 8'h00, 4'b1000); tick();
        idle_to(10);
        drive(4'b0, 8'h0, 8'h08, 4'b0); tick();
        drive(4'b0, 8'h0, 8'h04, 4'b0); tick();
        // underflow: 2 requested, 1 held
        drive(4'b0100, 8'h20, 8'h00, 4'b0100);
        chk("err_pre_uf", 32'(bus.err), 0);
        tick();
        drive(4'b0, 8'h0, 8'h20, 4'b0);
        chk("uf_sel", 32'(bus.sel[2]), 32'h1);
        tick();
        drive(4'b0, 8'h0, 8'h0, 4'b0);
        chk("err_uf", 32'(bus.err), 32'h2);
        tick();
        // dual return: port 2 slot 4, port 3 slot 5 on bank 0
        idle_to(34);
        drive(4'b0100, 8'h00, 8'h00, 4'b0100); tick();
        drive(4'b1000, 8'h00, 8'h00, 4'b1000); tick();
        drive(4'b0, 8'h0, 8'h02, 4'b0);
        chk("dual_sel", 32'(bus.sel[0]), 32'h4);
        chk("dual_prt", 32'(bus.prt[0]), 32'hE);
        chk("dual_ptr", 32'(bus.ptr[0]), 32'h0A4);
        tick();
        drive(4'b0, 8'h0, 8'h01, 4'b0);
        chk("empty_sel", 32'(bus.sel[0]), 0);
        tick();
        // missed deadline: port 1 -> bank 3, never returned
        idle_to(40);
        drive(4'b0010, 8'h0C, 8'h00, 4'b0010); tick();
        idle_to(69);
        drive(4'b0, 8'h0, 8'h0, 4'b0);
        chk("err_pre_miss", 32'(bus.err), 32'h2);
        tick();
        drive(4'b0, 8'h0, 8'h0, 4'b0);
        chk("err_miss", 32'(bus.err), 32'h3);
        tick();
        // full FIFO: 8 unreturned reads to bank 0, 9th refused
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001, 8'h00, 8'h00, 4'b0001);
            tick();
        end
        drive(4'b0001, 8'h00, 8'h00, 4'b0000);
        chk("full_gnt", 32'(bus.rd_gnt[0]), 0);
        chk("err_sticky", 32'(bus.err), 32'h3);
        tick();
        // async reset mid-flight
        drive(4'b0001, 8'h00, 8'h00, 4'b0000);
        #2;
        rst_n = 1'b0;
        bus.rd_req = 4'b1111;
        bus.rd_bnk = 8'hE4;
        bus.ret_cnt = 8'hFF;
        #1;
        chk_reset("midrst");
        sb.delete();
        for (int b = 0; b < 4; b++) bq[b].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        drive(4'b0, 8'h0, 8'h0, 4'b0);
        chk("post_rst_slot", 32'(bus.drn_slot), 1);
        tick();
        drive(4'b0, 8'h0, 8'h01, 4'b0);
        chk("post_rst_sel", 32'(bus.sel[0]), 0);
        tick();
        drive(4'b0, 8'h0, 8'h0, 4'b0);
        chk("post_rst_err", 32'(bus.err), 32'h2);
        tick();
        // late return exactly at the drain cycle
        drive(4'b0001, 8'h02, 8'h00, 4'b0001); tick();
        idle_to(32);
        drive(4'b0, 8'h0, 8'h10, 4'b0);
        chk("late_sel", 32'(bus.sel[2]), 32'h1);
        chk("late_err_pre", 32'(bus.err), 32'h2);
        tick();
        drive(4'b0, 8'h0, 8'h0, 4'b0);
        chk("late_err", 32'(bus.err), 32'h3);
        tick();
        idle_to(36);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
